// File: rtl/status_encoder_pkg.sv
// ============================================================================
// Module      : status_encoder_pkg
// Description : Shared request ids, frame codes, FSM states and CRC-8 step
//               for the host-bound status/config frame encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package status_encoder_pkg;

  localparam logic [3:0] REQ_CONFIG  = 4'd1;
  localparam logic [3:0] REQ_STATUS  = 4'd2;

  localparam logic [7:0] TYPE_CONFIG = 8'h01;
  localparam logic [7:0] TYPE_STATUS = 8'h02;

  localparam logic [7:0] CFG_LEN     = 8'd12;
  localparam logic [7:0] STS_LEN     = 8'd4;
  localparam logic [7:0] NAK_LEN     = 8'd1;

  localparam logic [7:0] CRC8_POLY   = 8'h07;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_TYPE    = 3'd2,
    ST_LEN     = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_CSUM    = 3'd5
  } enc_state_t;

  // MSB-first CRC-8 over one byte, no reflection
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/status_encoder_checksum.sv
// ============================================================================
// Module      : frame_checksum
// Description : Running frame checksum with clear/update. XOR by default,
//               CRC-8 (poly 0x07) when STATUS_ENC_CRC8_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_checksum
  import status_encoder_pkg::*;
(
  input  logic       CLK300MHZ,
  input  logic       RST,
  input  logic       clear,
  input  logic       update,
  input  logic [7:0] data,
  output logic [7:0] sum_next
);

  logic [7:0] r_sum;

`ifdef STATUS_ENC_CRC8_EN
  assign sum_next = crc8_byte(r_sum, data);
`else
  assign sum_next = r_sum ^ data;
`endif

  always_ff @(posedge CLK300MHZ or posedge RST) begin
    if (RST) begin
      r_sum <= 8'h00;
    end else if (clear) begin
      r_sum <= 8'h00;
    end else if (update) begin
      r_sum <= sum_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/status_encoder.sv
// ============================================================================
// Module      : status_encoder
// Description : Snapshots config/status words on request and streams them as
//               a sync/type/len/payload/checksum byte frame (stb/ack).
//               Checksum becomes CRC-8 when STATUS_ENC_CRC8_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module status_encoder
  import status_encoder_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter logic [7:0] NAK_TYPE  = 8'hFF
) (
  input  logic        CLK300MHZ,
  input  logic        RST,
  input  logic        req_stb,
  input  logic [3:0]  req_id,
  input  logic [15:0] samp_freq,
  input  logic [23:0] samp_num,
  input  logic [3:0]  trig_type,
  input  logic [3:0]  trig_ch,
  input  logic [15:0] ch_bitmap,
  input  logic [7:0]  voltage_th,
  input  logic [16:0] trig_position,
  input  logic        trig_fired,
  input  logic        capture_active,
  input  logic        fifo_full,
  input  logic        fifo_empty,
  input  logic [16:0] fifo_count,
  output logic [7:0]  data_out,
  output logic        stb_out,
  input  logic        ack_out,
  output logic        busy,
  output logic [7:0]  drop_cnt
);

  enc_state_t  r_state, w_state;
  logic [95:0] r_payload, w_payload;
  logic [7:0]  r_type, w_type;
  logic [7:0]  r_len, w_len;
  logic [3:0]  r_cnt, w_cnt;
  logic        r_pend_valid, w_pend_valid;
  logic [3:0]  r_pend_id, w_pend_id;
  logic [7:0]  w_data, w_drop, w_cs_next;
  logic        w_stb, w_busy, w_xfer, w_start, w_cs_update;
  logic [3:0]  w_start_id;

  frame_checksum u_checksum (
    .CLK300MHZ (CLK300MHZ),
    .RST       (RST),
    .clear     (w_start),
    .update    (w_cs_update),
    .data      (data_out),
    .sum_next  (w_cs_next)
  );

  always_comb begin
    w_state      = r_state;
    w_payload    = r_payload;
    w_type       = r_type;
    w_len        = r_len;
    w_cnt        = r_cnt;
    w_pend_valid = r_pend_valid;
    w_pend_id    = r_pend_id;
    w_data       = data_out;
    w_stb        = stb_out;
    w_drop       = drop_cnt;
    w_start      = 1'b0;
    w_start_id   = req_id;
    w_cs_update  = 1'b0;
    w_xfer       = stb_out & ack_out;

    case (r_state)
      ST_IDLE: if (req_stb) w_start = 1'b1;
      ST_SYNC: if (w_xfer) begin
        w_state = ST_TYPE;
        w_data  = r_type;
      end
      ST_TYPE: if (w_xfer) begin
        w_state     = ST_LEN;
        w_data      = r_len;
        w_cs_update = 1'b1;
      end
      ST_LEN: if (w_xfer) begin
        w_state     = ST_PAYLOAD;
        w_data      = r_payload[95:88];
        w_cs_update = 1'b1;
      end
      ST_PAYLOAD: if (w_xfer) begin
        w_cs_update = 1'b1;
        if (r_cnt == 4'd1) begin
          // last payload byte folded in combinationally
          w_state = ST_CSUM;
          w_data  = w_cs_next;
        end else begin
          w_payload = r_payload << 8;
          w_data    = r_payload[87:80];
          w_cnt     = r_cnt - 4'd1;
        end
      end
      ST_CSUM: if (w_xfer) begin
        if (r_pend_valid) begin
          w_start      = 1'b1;
          w_start_id   = r_pend_id;
          w_pend_valid = req_stb;
          w_pend_id    = req_id;
        end else if (req_stb) begin
          w_start = 1'b1;
        end else begin
          w_state = ST_IDLE;
          w_stb   = 1'b0;
          w_data  = 8'h00;
        end
      end
      default: w_state = ST_IDLE;
    endcase

    if (req_stb && (r_state != ST_IDLE) && !((r_state == ST_CSUM) && w_xfer)) begin
      if (!r_pend_valid) begin
        w_pend_valid = 1'b1;
        w_pend_id    = req_id;
      end else if (drop_cnt != 8'hFF) begin
        w_drop = drop_cnt + 8'd1;
      end
    end

    if (w_start) begin
      w_state = ST_SYNC;
      w_data  = SYNC_BYTE;
      w_stb   = 1'b1;
      case (w_start_id)
        REQ_CONFIG: begin
          w_type    = TYPE_CONFIG;
          w_len     = CFG_LEN;
          w_payload = {samp_freq, samp_num, trig_ch, trig_type, ch_bitmap,
                       voltage_th, 7'b0, trig_position};
        end
        REQ_STATUS: begin
          w_type    = TYPE_STATUS;
          w_len     = STS_LEN;
          w_payload = {trig_fired, capture_active, fifo_full, fifo_empty, 4'b0,
                       7'b0, fifo_count, 64'b0};
        end
        default: begin
          w_type    = NAK_TYPE;
          w_len     = NAK_LEN;
          w_payload = {4'b0, w_start_id, 88'b0};
        end
      endcase
      w_cnt = w_len[3:0];
    end

    w_busy = (w_state != ST_IDLE) | w_pend_valid;
  end

  always_ff @(posedge CLK300MHZ or posedge RST) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_payload    <= '0;
      r_type       <= 8'h00;
      r_len        <= 8'h00;
      r_cnt        <= 4'd0;
      r_pend_valid <= 1'b0;
      r_pend_id    <= 4'd0;
      data_out     <= 8'h00;
      stb_out      <= 1'b0;
      busy         <= 1'b0;
      drop_cnt     <= 8'h00;
    end else begin
      r_state      <= w_state;
      r_payload    <= w_payload;
      r_type       <= w_type;
      r_len        <= w_len;
      r_cnt        <= w_cnt;
      r_pend_valid <= w_pend_valid;
      r_pend_id    <= w_pend_id;
      data_out     <= w_data;
      stb_out      <= w_stb;
      busy         <= w_busy;
      drop_cnt     <= w_drop;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_status_encoder.sv
// ============================================================================
// Module      : tb_status_encoder
// Description : Self-checking bench for status_encoder against a byte-list
//               frame model (honours STATUS_ENC_CRC8_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_status_encoder;

  logic        CLK300MHZ = 1'b0;
  logic        RST = 1'b1;
  logic        req_stb = 1'b0;
  logic [3:0]  req_id = 4'd0;
  logic [15:0] samp_freq = '0;
  logic [23:0] samp_num = '0;
  logic [3:0]  trig_type = '0;
  logic [3:0]  trig_ch = '0;
  logic [15:0] ch_bitmap = '0;
  logic [7:0]  voltage_th = '0;
  logic [16:0] trig_position = '0;
  logic        trig_fired = 1'b0;
  logic        capture_active = 1'b0;
  logic        fifo_full = 1'b0;
  logic        fifo_empty = 1'b0;
  logic [16:0] fifo_count = '0;
  logic [7:0]  data_out;
  logic        stb_out;
  logic        ack_out = 1'b1;
  logic        busy;
  logic [7:0]  drop_cnt;

  logic        rand_ack = 1'b0;
  logic        ack_fixed = 1'b1;

  int checks = 0;
  int errors = 0;
  int exp_drop = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] body[$];
  logic [7:0] held = 8'h00;
  logic       held_v = 1'b0;

  status_encoder dut (
    .CLK300MHZ      (CLK300MHZ),
    .RST            (RST),
    .req_stb        (req_stb),
    .req_id         (req_id),
    .samp_freq      (samp_freq),
    .samp_num       (samp_num),
    .trig_type      (trig_type),
    .trig_ch        (trig_ch),
    .ch_bitmap      (ch_bitmap),
    .voltage_th     (voltage_th),
    .trig_position  (trig_position),
    .trig_fired     (trig_fired),
    .capture_active (capture_active),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty),
    .fifo_count     (fifo_count),
    .data_out       (data_out),
    .stb_out        (stb_out),
    .ack_out        (ack_out),
    .busy           (busy),
    .drop_cnt       (drop_cnt)
  );

  always #5 CLK300MHZ = ~CLK300MHZ;

  always @(posedge CLK300MHZ) begin
    #1;
    ack_out = rand_ack ? ($urandom_range(0, 2) != 0) : ack_fixed;
  end

  // Collect transferred bytes; a stalled byte must be held unchanged
  always @(negedge CLK300MHZ) begin
    if (held_v) begin
      checks++;
      assert (stb_out === 1'b1 && data_out === held)
      else begin
        errors++;
        $error("FAIL hold_stable got stb=%0b data=%h exp stb=1 data=%h", stb_out, data_out, held);
      end
    end
    held_v = stb_out && !ack_out && !RST;
    held   = data_out;
    if (stb_out && ack_out) rx_q.push_back(data_out);
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK300MHZ);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic void push_field(input logic [31:0] v, input int n);
    for (int b = n - 1; b >= 0; b--) body.push_back(8'(v >> (8 * b)));
  endfunction

  // Expected frame from the current input values, appended to exp_q
  function automatic void model_frame(input logic [3:0] id);
    logic [7:0] cs;
    body.delete();
    if (id == 4'd1) begin
      push_field(32'h01, 1);
      push_field(32'd12, 1);
      push_field(32'(samp_freq), 2);
      push_field(32'(samp_num), 3);
      push_field(32'({trig_ch, trig_type}), 1);
      push_field(32'(ch_bitmap), 2);
      push_field(32'(voltage_th), 1);
      push_field(32'(trig_position), 3);
    end else if (id == 4'd2) begin
      push_field(32'h02, 1);
      push_field(32'd4, 1);
      push_field(32'({trig_fired, capture_active, fifo_full, fifo_empty, 4'b0}), 1);
      push_field(32'(fifo_count), 3);
    end else begin
      push_field(32'hFF, 1);
      push_field(32'd1, 1);
      push_field(32'(id), 1);
    end
    cs = 8'h00;
    foreach (body[i]) begin
`ifdef STATUS_ENC_CRC8_EN
      cs = cs ^ body[i];
      for (int k = 0; k < 8; k++) cs = cs[7] ? ((cs << 1) ^ 8'h07) : (cs << 1);
`else
      cs = cs ^ body[i];
`endif
    end
    exp_q.push_back(8'hA5);
    foreach (body[i]) exp_q.push_back(body[i]);
    exp_q.push_back(cs);
  endfunction

  task automatic randomize_inputs();
    samp_freq      = 16'($urandom);
    samp_num       = 24'($urandom);
    trig_type      = 4'($urandom);
    trig_ch        = 4'($urandom);
    ch_bitmap      = 16'($urandom);
    voltage_th     = 8'($urandom);
    trig_position  = 17'($urandom);
    trig_fired     = 1'($urandom);
    capture_active = 1'($urandom);
    fifo_full      = 1'($urandom);
    fifo_empty     = 1'($urandom);
    fifo_count     = 17'($urandom);
  endtask

  task automatic pulse_req(input logic [3:0] id);
    req_id  = id;
    req_stb = 1'b1;
    tick();
    req_stb = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input string tag);
    int cyc;
    cyc = 0;
    while (rx_q.size() < n && cyc < 3000) begin
      tick();
      cyc++;
    end
    chk({tag, "_bytes_arrived"}, 32'(rx_q.size() >= n), 32'd1);
  endtask

  task automatic check_frame(input string tag);
    int n;
    logic [7:0] a;
    n = exp_q.size();
    wait_bytes(n, tag);
    for (int i = 0; i < n; i++) begin
      a = 8'hxx;
      if (rx_q.size() != 0) a = rx_q.pop_front();
      chk($sformatf("%s_byte%0d", tag, i), 32'(a), 32'(exp_q[i]));
    end
    exp_q.delete();
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while (busy !== 1'b0 && cyc < 3000) begin
      tick();
      cyc++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic set_spec_config();
    samp_freq     = 16'h1234;
    samp_num      = 24'h0A0B0C;
    trig_type     = 4'd3;
    trig_ch       = 4'd5;
    ch_bitmap     = 16'h00FF;
    voltage_th    = 8'h80;
    trig_position = 17'h10203;
  endtask

  initial begin
    logic [3:0] rid;

    tick();
    tick();
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_stb_out", 32'(stb_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
    RST = 1'b0;
    tick();

    // CONFIG, ack held high: 16 consecutive bytes starting N+1
    set_spec_config();
    model_frame(4'd1);
    pulse_req(4'd1);
    chk("cfg_first_stb", 32'(stb_out), 32'd1);
    chk("cfg_first_sync", 32'(data_out), 32'hA5);
    chk("cfg_busy", 32'(busy), 32'd1);
    repeat (16) tick();
    chk("cfg_count_16", 32'(rx_q.size()), 32'd16);
    chk("cfg_stb_low_after", 32'(stb_out), 32'd0);
    chk("cfg_busy_low_after", 32'(busy), 32'd0);
    check_frame("cfg");

    // STATUS
    trig_fired = 1'b1; capture_active = 1'b0; fifo_full = 1'b0; fifo_empty = 1'b1;
    fifo_count = 17'h00100;
    model_frame(4'd2);
    pulse_req(4'd2);
    check_frame("sts");
    wait_idle();

    // Unknown id
    model_frame(4'd7);
    pulse_req(4'd7);
    check_frame("nak");
    wait_idle();

    // Backpressure with inputs changed mid-frame
    set_spec_config();
    model_frame(4'd1);
    rand_ack = 1'b1;
    pulse_req(4'd1);
    repeat (4) tick();
    randomize_inputs();
    check_frame("bp_cfg");
    wait_idle();

    // Randomised frames under random backpressure
    for (int it = 0; it < 8; it++) begin
      randomize_inputs();
      case ($urandom_range(0, 2))
        0: rid = 4'd1;
        1: rid = 4'd2;
        default: rid = 4'($urandom);
      endcase
      model_frame(rid);
      pulse_req(rid);
      repeat (3) tick();
      randomize_inputs();
      check_frame($sformatf("rnd%0d", it));
      wait_idle();
    end

    // Three consecutive requests: two frames back-to-back, one drop
    rand_ack = 1'b0;
    ack_fixed = 1'b1;
    tick();
    tick();
    rx_q.delete();
    set_spec_config();
    model_frame(4'd1);
    model_frame(4'd2);
    req_stb = 1'b1;
    req_id = 4'd1; tick();
    req_id = 4'd2; tick();
    req_id = 4'd7; tick();
    req_stb = 1'b0;
    exp_drop = exp_drop + 1;
    chk("ovf_drop_1", 32'(drop_cnt), 32'(exp_drop));
    repeat (22) tick();
    chk("ovf_b2b_count", 32'(rx_q.size()), 32'd24);
    chk("ovf_stb_low_after", 32'(stb_out), 32'd0);
    check_frame("ovf");
    wait_idle();

    // Stall the stream and drop 300 more requests
    ack_fixed = 1'b0;
    tick();
    tick();
    model_frame(4'd1);
    model_frame(4'd2);
    req_stb = 1'b1;
    req_id = 4'd1; tick();
    req_id = 4'd2; tick();
    for (int i = 0; i < 300; i++) begin
      req_id = 4'($urandom);
      tick();
    end
    req_stb = 1'b0;
    exp_drop = (exp_drop + 300 > 255) ? 255 : exp_drop + 300;
    chk("sat_drop_ff", 32'(drop_cnt), 32'(exp_drop));
    chk("sat_stall_data", 32'(data_out), 32'hA5);
    ack_fixed = 1'b1;
    check_frame("sat");
    wait_idle();

    // Reset mid-frame after the 5th byte
    set_spec_config();
    model_frame(4'd1);
    pulse_req(4'd1);
    wait_bytes(5, "rstmid");
    #2;
    RST = 1'b1;
    #1;
    chk("rstmid_stb", 32'(stb_out), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rstmid_prefix%0d", i), 32'(rx_q.size() > i ? rx_q[i] : 8'hxx), 32'(exp_q[i]));
    end
    tick();
    tick();
    RST = 1'b0;
    rx_q.delete();
    exp_q.delete();
    tick();
    chk("rstmid_drop_cleared", 32'(drop_cnt), 32'd0);
    model_frame(4'd1);
    pulse_req(4'd1);
    chk("rstmid_new_sync", 32'(data_out), 32'hA5);
    check_frame("rstmid_new");
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
